// File: rtl/dtc_pkg.sv
// Shared types and constants for the decision-tree classifier request arbiter.
package dtc_pkg;

  localparam int unsigned DTC_FEAT_W  = 12;
  localparam int unsigned DTC_CLASS_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } dtc_arb_state_e;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned dtc_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dtc_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping upward.
module dtc_rr_pick
  import dtc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = dtc_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_valid,
  output logic [ID_W-1:0]    o_idx
);

  logic [ID_W:0] w_pos;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // i_ptr < NUM_REQ, so a single subtraction completes the modulo
      w_pos = {1'b0, i_ptr} + (ID_W + 1)'(k);
      if (w_pos >= (ID_W + 1)'(NUM_REQ)) begin
        w_pos = w_pos - (ID_W + 1)'(NUM_REQ);
      end
      if (!o_valid && i_req[w_pos[ID_W-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_pos[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dtc_req_arbiter.sv
// Round-robin arbiter sharing one combinational decision-tree classifier among requesters.
// Define DTC_CLASS_HIST_EN to build the per-class response histogram.
module dtc_req_arbiter
  import dtc_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned FEAT_W  = DTC_FEAT_W,
  parameter  int unsigned CLASS_W = DTC_CLASS_W,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned ID_W    = dtc_id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FEAT_W-1:0] req_feat,
  output logic [FEAT_W-1:0]         dt_inp,
  input  logic [CLASS_W-1:0]        dt_outp,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [CLASS_W-1:0]        rsp_class,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy,
  input  logic [CLASS_W-1:0]        hist_sel,
  output logic [CNT_W-1:0]          hist_cnt
);

  dtc_arb_state_e      r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  logic [FEAT_W-1:0]   r_feat;
  logic [CLASS_W-1:0]  r_class;

  logic                w_grant_valid;
  logic [ID_W-1:0]     w_grant_idx;
  logic [ID_W-1:0]     w_next_ptr;
  logic [FEAT_W-1:0]   w_grant_feat;
  logic                w_rsp_fire;

  dtc_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_grant_valid),
    .o_idx   (w_grant_idx)
  );

  assign w_grant_feat = req_feat[w_grant_idx*FEAT_W +: FEAT_W];
  assign w_next_ptr   = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
  assign w_rsp_fire   = (r_state == RESP) && rsp_ready;

  // Accept is a same-cycle handshake, so ready is driven straight from the picker
  always_comb begin
    req_ready = '0;
    if (r_state == IDLE && w_grant_valid) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_feat   <= '0;
      r_class  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_feat   <= w_grant_feat;
            r_id     <= w_grant_idx;
            r_rr_ptr <= w_next_ptr;
            r_state  <= EVAL;
          end
        end
        EVAL: begin
          r_class <= dt_outp;
          r_state <= RESP;
        end
        RESP: begin
          if (w_rsp_fire) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dt_inp    = r_feat;
  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_class = r_class;
  assign rsp_id    = r_id;

`ifdef DTC_CLASS_HIST_EN
  logic [CNT_W-1:0] r_hist [2**CLASS_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**CLASS_W; i++) begin
        r_hist[i] <= '0;
      end
    end else if (w_rsp_fire && (r_hist[r_class] != '1)) begin
      r_hist[r_class] <= r_hist[r_class] + CNT_W'(1);
    end
  end

  assign hist_cnt = r_hist[hist_sel];
`else
  logic w_unused_hist_sel;
  assign w_unused_hist_sel = ^hist_sel;
  assign hist_cnt          = '0;
`endif

endmodule
